// File: rtl/spi_device_core.sv
// SPI slave core: synchronised pin inputs, register-bus RX/TX/CTRL/STATUS, and a
// character-level shift engine with overrun/underrun tracking and a level interrupt.
module spi_device_core #(
  parameter int unsigned MAX_CHAR    = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  input  logic [3:0]  be_i,
  input  logic        we_i,
  input  logic        re_i,
  output logic        error_o,
  output logic        intr_o,
  input  logic        ss_ni,
  input  logic        sclk_i,
  input  logic        sd_i,
  output logic        sd_o,
  output logic        sd_oe_o
);

  localparam int unsigned CntW = $clog2(MAX_CHAR);

  localparam logic [0:0] StIdle   = 1'b0;
  localparam logic [0:0] StActive = 1'b1;

  logic [SYNC_STAGES-1:0] sclk_sync_q, ss_sync_q, sd_sync_q;
  logic                   sclk_prev_q, ss_prev_q;

  logic [0:0]          state_q, state_d;
  logic [12:0]         ctrl_q, ctrl_d;
  logic [31:0]         tx_buf_q, tx_buf_d;
  logic [31:0]         rx_reg_q, rx_reg_d;
  logic [MAX_CHAR-1:0] tx_shift_q, tx_shift_d;
  logic [MAX_CHAR-1:0] rx_shift_q, rx_shift_d;
  logic [CntW-1:0]     bit_cnt_q, bit_cnt_d;
  logic                rx_valid_q, rx_valid_d;
  logic                tx_full_q, tx_full_d;
  logic                overrun_q, overrun_d;
  logic                underrun_q, underrun_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                intr_q, sd_q, sd_d;

  logic            sclk_s, ss_s, sd_s;
  logic            sclk_rise, sclk_fall, ss_fall;
  logic            sample_edge, drive_edge;
  logic            busy, rd_rx, tx_wr, reload;
  logic [4:0]      char_len;
  logic [CntW-1:0] len_m1;
  logic            rx_negedge, tx_negedge, lsb, ie, en;
  logic [MAX_CHAR-1:0] rx_base;
  logic [5:0]      unused_addr;

  assign unused_addr = {addr_i[7:4], addr_i[1:0]};

  assign char_len   = ctrl_q[4:0];
  assign rx_negedge = ctrl_q[8];
  assign tx_negedge = ctrl_q[9];
  assign lsb        = ctrl_q[10];
  assign ie         = ctrl_q[11];
  assign en         = ctrl_q[12];

  // char_len of zero selects the full MAX_CHAR width
  assign len_m1 = (char_len == 5'd0) ? CntW'(MAX_CHAR - 1) : CntW'(char_len - 5'd1);

  assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
  assign ss_s        = ss_sync_q[SYNC_STAGES-1];
  assign sd_s        = sd_sync_q[SYNC_STAGES-1];
  assign sclk_rise   = sclk_s & ~sclk_prev_q;
  assign sclk_fall   = ~sclk_s & sclk_prev_q;
  assign ss_fall     = ss_prev_q & ~ss_s;
  assign sample_edge = rx_negedge ? sclk_fall : sclk_rise;
  assign drive_edge  = tx_negedge ? sclk_fall : sclk_rise;

  assign busy  = (state_q == StActive);
  assign rd_rx = re_i && (addr_i[3:2] == 2'd0);
  assign tx_wr = we_i && (addr_i[3:2] == 2'd1);

  always_comb begin
    state_d    = state_q;
    ctrl_d     = ctrl_q;
    tx_buf_d   = tx_buf_q;
    rx_reg_d   = rx_reg_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    bit_cnt_d  = bit_cnt_q;
    rx_valid_d = rx_valid_q;
    tx_full_d  = tx_full_q;
    overrun_d  = overrun_q;
    underrun_d = underrun_q;
    reload     = 1'b0;
    rx_base    = '0;

    if (rd_rx) rx_valid_d = 1'b0;

    if (we_i) begin
      unique case (addr_i[3:2])
        2'd1: begin
          for (int b = 0; b < 4; b++) begin
            if (be_i[b]) tx_buf_d[8*b +: 8] = wdata_i[8*b +: 8];
          end
        end
        2'd2: begin
          if (!busy) begin
            if (be_i[0]) ctrl_d[4:0]  = wdata_i[4:0];
            if (be_i[1]) ctrl_d[12:8] = wdata_i[12:8];
          end
        end
        2'd3: begin
          if (wdata_i[2]) overrun_d  = 1'b0;
          if (wdata_i[3]) underrun_d = 1'b0;
        end
        default: ;
      endcase
    end

    unique case (state_q)
      StIdle: begin
        if (en && ss_fall) begin
          state_d = StActive;
          reload  = 1'b1;
        end
      end
      StActive: begin
        if (ss_s) begin
          state_d = StIdle;
        end else begin
          if (sample_edge) begin
            rx_base = (bit_cnt_q == '0) ? '0 : rx_shift_q;
            if (lsb) begin
              rx_shift_d            = rx_base;
              rx_shift_d[bit_cnt_q] = sd_s;
            end else begin
              rx_shift_d = {rx_base[MAX_CHAR-2:0], sd_s};
            end
            if (bit_cnt_q == len_m1) begin
              // A same-cycle RX read frees the holding register, so no overrun
              if (rx_valid_q && !rd_rx) begin
                overrun_d = 1'b1;
              end else begin
                rx_reg_d   = 32'(rx_shift_d);
                rx_valid_d = 1'b1;
              end
              reload = 1'b1;
            end else begin
              bit_cnt_d = bit_cnt_q + CntW'(1);
            end
          end
          // Drive edges preceding the first sample of a character keep bit 0 on the pin
          if (drive_edge && !reload && (bit_cnt_q != '0 || sample_edge)) begin
            tx_shift_d = lsb ? (tx_shift_q >> 1) : (tx_shift_q << 1);
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (reload) begin
      tx_shift_d = tx_full_q ? tx_buf_q[MAX_CHAR-1:0] : '0;
      if (!tx_full_q) underrun_d = 1'b1;
      tx_full_d = 1'b0;
      bit_cnt_d = '0;
    end

    // Bus write wins over a same-cycle reload, which already used the old buffer
    if (tx_wr) tx_full_d = 1'b1;
  end

  always_comb begin
    sd_d = 1'b0;
    if (state_d == StActive) sd_d = lsb ? tx_shift_d[0] : tx_shift_d[len_m1];
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re_i) begin
      unique case (addr_i[3:2])
        2'd0:    rdata_d = rx_reg_q;
        2'd1:    rdata_d = tx_buf_q;
        2'd2:    rdata_d = {19'd0, ctrl_q[12:8], 3'd0, ctrl_q[4:0]};
        default: rdata_d = {27'd0, busy, underrun_q, overrun_q, tx_full_q, rx_valid_q};
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sclk_sync_q <= '0;
      ss_sync_q   <= '0;
      sd_sync_q   <= '0;
      sclk_prev_q <= 1'b0;
      ss_prev_q   <= 1'b0;
      state_q     <= StIdle;
      ctrl_q      <= '0;
      tx_buf_q    <= '0;
      rx_reg_q    <= '0;
      tx_shift_q  <= '0;
      rx_shift_q  <= '0;
      bit_cnt_q   <= '0;
      rx_valid_q  <= 1'b0;
      tx_full_q   <= 1'b0;
      overrun_q   <= 1'b0;
      underrun_q  <= 1'b0;
      rdata_q     <= '0;
      intr_q      <= 1'b0;
      sd_q        <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_i};
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], ss_ni};
      sd_sync_q   <= {sd_sync_q[SYNC_STAGES-2:0], sd_i};
      sclk_prev_q <= sclk_s;
      ss_prev_q   <= ss_s;
      state_q     <= state_d;
      ctrl_q      <= ctrl_d;
      tx_buf_q    <= tx_buf_d;
      rx_reg_q    <= rx_reg_d;
      tx_shift_q  <= tx_shift_d;
      rx_shift_q  <= rx_shift_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_valid_q  <= rx_valid_d;
      tx_full_q   <= tx_full_d;
      overrun_q   <= overrun_d;
      underrun_q  <= underrun_d;
      rdata_q     <= rdata_d;
      intr_q      <= ie & (rx_valid_q | overrun_q | underrun_q);
      sd_q        <= sd_d;
    end
  end

  assign rdata_o = rdata_q;
  assign intr_o  = intr_q;
  assign sd_o    = sd_q;
  assign sd_oe_o = busy;
  assign error_o = 1'b0;

endmodule

// File: tb/tb_spi_device_core.sv
// Directed bench for spi_device_core: a bus-functional SPI master plus register accesses,
// with expected MISO/RX words queued at stimulus time and popped when observed.
module tb_spi_device_core;

  localparam logic [7:0] ARx = 8'h00, ATx = 8'h04, ACtrl = 8'h08, AStat = 8'h0C;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [7:0]  addr_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;
  logic [3:0]  be_i;
  logic        we_i, re_i;
  logic        error_o, intr_o;
  logic        ss_ni, sclk_i, sd_i;
  logic        sd_o, sd_oe_o;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;
  logic [31:0] exp_q[$];

  spi_device_core #(.MAX_CHAR(32), .SYNC_STAGES(2)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .addr_i  (addr_i),
    .wdata_i (wdata_i),
    .rdata_o (rdata_o),
    .be_i    (be_i),
    .we_i    (we_i),
    .re_i    (re_i),
    .error_o (error_o),
    .intr_o  (intr_o),
    .ss_ni   (ss_ni),
    .sclk_i  (sclk_i),
    .sd_i    (sd_i),
    .sd_o    (sd_o),
    .sd_oe_o (sd_oe_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_pop(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_bad++;
      $error("FAIL %s: observed %h expected <scoreboard empty>", tag, obs);
    end else begin
      e = exp_q.pop_front();
      chk(tag, obs, e);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge clk_i);
    addr_i = a; wdata_i = d; be_i = be; we_i = 1'b1;
    @(negedge clk_i);
    we_i = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] d);
    @(negedge clk_i);
    addr_i = a; re_i = 1'b1;
    @(negedge clk_i);
    re_i = 1'b0;
    d = rdata_o;
  endtask

  // CPOL=0 master; cpha=0 samples MISO at the rising edge, cpha=1 at the falling edge
  task automatic xfer(input int nbits, input logic [31:0] mosi, input bit cpha, input bit lsb,
                      output logic [31:0] miso);
    int idx;
    miso = '0;
    for (int i = 0; i < nbits; i++) begin
      idx = lsb ? i : nbits - 1 - i;
      if (!cpha) begin
        sd_i = mosi[idx];
        wait_clk(8);
        miso[idx] = sd_o;
        sclk_i = 1'b1;
        wait_clk(8);
        sclk_i = 1'b0;
      end else begin
        sclk_i = 1'b1;
        sd_i = mosi[idx];
        wait_clk(8);
        miso[idx] = sd_o;
        sclk_i = 1'b0;
        wait_clk(8);
      end
    end
  endtask

  task automatic ss_low;
    ss_ni = 1'b0;
    wait_clk(8);
  endtask

  task automatic ss_high;
    wait_clk(8);
    ss_ni = 1'b1;
    wait_clk(8);
  endtask

  initial begin
    logic [31:0] d, m;
    rst_i = 1'b1; addr_i = '0; wdata_i = '0; be_i = '0; we_i = 1'b0; re_i = 1'b0;
    ss_ni = 1'b1; sclk_i = 1'b0; sd_i = 1'b0;
    wait_clk(3);
    chk("rst_rdata", rdata_o, 32'h0);
    chk("rst_intr", {31'd0, intr_o}, 32'h0);
    chk("rst_sd_oe", {30'd0, sd_oe_o, sd_o}, 32'h0);
    chk("rst_error", {31'd0, error_o}, 32'h0);
    rst_i = 1'b0;
    wait_clk(4);
    rd(ACtrl, d); chk("ctrl_after_rst", d, 32'h0);
    rd(AStat, d); chk("stat_after_rst", d, 32'h0);

    // Byte enables and unmapped CTRL bits
    wr(ACtrl, 32'h0000_FFFF, 4'b0001);
    rd(ACtrl, d); chk("ctrl_be0", d, 32'h0000_001F);
    wr(ACtrl, 32'hFFFF_1808, 4'b0011);
    rd(ACtrl, d); chk("ctrl_be01", d, 32'h0000_1808);

    // 1: mode 0, 8 bits, TX=A5, master sends 3C
    wr(ATx, 32'h0000_00A5, 4'hF);
    rd(AStat, d); chk("t1_stat_txfull", d, 32'h2);
    chk("t1_intr_idle", {31'd0, intr_o}, 32'h0);
    exp_q.push_back(32'hA5); exp_q.push_back(32'h3C);
    ss_low; xfer(8, 32'h3C, 1'b0, 1'b0, m); ss_high;
    chk_pop("t1_miso", m);
    rd(AStat, d); chk("t1_stat", d, 32'h9);
    chk("t1_intr", {31'd0, intr_o}, 32'h1);
    rd(ARx, d); chk_pop("t1_rx", d);
    rd(AStat, d); chk("t1_stat_rd", d, 32'h8);
    wr(AStat, 32'h8, 4'hF);
    wait_clk(3);
    chk("t1_intr_clr", {31'd0, intr_o}, 32'h0);

    // 2: sample on fall, drive on rise, LSB first
    wr(ACtrl, 32'h0000_1D08, 4'hF);
    wr(ATx, 32'h0000_0001, 4'hF);
    exp_q.push_back(32'h01); exp_q.push_back(32'h80);
    ss_low; xfer(8, 32'h80, 1'b1, 1'b1, m); ss_high;
    chk_pop("t2_miso", m);
    rd(ARx, d); chk_pop("t2_rx", d);

    // 3: two characters without an RX read
    wr(AStat, 32'h8, 4'hF);
    wr(ACtrl, 32'h0000_1808, 4'hF);
    wr(ATx, 32'h0000_0011, 4'hF);
    exp_q.push_back(32'h11); exp_q.push_back(32'h00); exp_q.push_back(32'h5A);
    ss_low;
    xfer(8, 32'h5A, 1'b0, 1'b0, m); chk_pop("t3_miso0", m);
    xfer(8, 32'hC3, 1'b0, 1'b0, m); chk_pop("t3_miso1", m);
    ss_high;
    rd(AStat, d); chk("t3_stat", d, 32'hD);
    rd(ARx, d); chk_pop("t3_rx_first", d);
    wr(AStat, 32'h4, 4'hF);
    rd(AStat, d); chk("t3_w1c", d, 32'h8);

    // 4: no TX data before select; CTRL writes blocked while busy
    wr(AStat, 32'h8, 4'hF);
    exp_q.push_back(32'h00); exp_q.push_back(32'h96);
    ss_low;
    rd(AStat, d); chk("t4_stat_busy", d, 32'h18);
    wr(ACtrl, 32'h0, 4'hF);
    xfer(8, 32'h96, 1'b0, 1'b0, m);
    ss_high;
    chk_pop("t4_miso", m);
    rd(AStat, d); chk("t4_stat", d, 32'h9);
    rd(ACtrl, d); chk("t4_ctrl_kept", d, 32'h1808);
    rd(ARx, d); chk_pop("t4_rx", d);

    // 5: select released after 5 of 8 bits, then a full character
    wr(AStat, 32'h8, 4'hF);
    wr(ATx, 32'h0000_00FF, 4'hF);
    exp_q.push_back(32'h1F);
    ss_low; xfer(5, 32'h15, 1'b0, 1'b0, m); ss_high;
    chk_pop("t5_miso_part", m);
    chk("t5_oe_idle", {31'd0, sd_oe_o}, 32'h0);
    rd(AStat, d); chk("t5_stat_part", d, 32'h0);
    wr(ATx, 32'h0000_005C, 4'hF);
    exp_q.push_back(32'h5C); exp_q.push_back(32'hE7);
    ss_low; xfer(8, 32'hE7, 1'b0, 1'b0, m); ss_high;
    chk_pop("t5_miso", m);
    rd(AStat, d); chk("t5_stat", d, 32'h9);
    rd(ARx, d); chk_pop("t5_rx", d);

    // 6: reset mid-character
    wait_clk(3);
    chk("t6_intr_pre", {31'd0, intr_o}, 32'h1);
    rd(AStat, d); chk("t6_stat_pre", d, 32'h8);
    wr(ATx, 32'h0000_0033, 4'hF);
    ss_low; xfer(3, 32'h5, 1'b0, 1'b0, m);
    chk("t6_pins_pre", {30'd0, sd_oe_o, sd_o}, 32'h3);
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    chk("t6_rdata", rdata_o, 32'h0);
    chk("t6_pins", {28'd0, error_o, intr_o, sd_oe_o, sd_o}, 32'h0);
    ss_ni = 1'b1; sclk_i = 1'b0;
    wait_clk(2);
    rst_i = 1'b0;
    wait_clk(4);
    rd(ACtrl, d); chk("t6_ctrl", d, 32'h0);
    rd(AStat, d); chk("t6_stat", d, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
